// File: rtl/sd_seq_pkg.sv
// ============================================================================
// Module   : sd_seq_pkg
// Purpose  : Shared types and constants for the sequence generator/checker pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_seq_pkg;

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    localparam int SEQ_CNT_W = 16;
    localparam int SEQ_PAT_W = 8;

    // Throttle patterns shared by generator and checker benches.
    localparam logic [SEQ_PAT_W-1:0] PAT_FULL = 8'hFF;
    localparam logic [SEQ_PAT_W-1:0] PAT_HALF = 8'b0101_0101;

endpackage : sd_seq_pkg

`default_nettype wire

// File: rtl/sd_seq_gen.sv
// ============================================================================
// Module   : sd_seq_gen
// Purpose  : Srdy/drdy producer emitting an incrementing, pattern-throttled
//            data sequence in bursts started by go.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_seq_gen
    import sd_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PAT_DEP = 8,
    parameter int CNT_W   = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [CNT_W-1:0]   count,
    input  logic [PAT_DEP-1:0] srdy_pat,
    output logic               p_srdy,
    input  logic               p_drdy,
    output logic [WIDTH-1:0]   p_data,
    output logic               busy,
    output logic               done
);

    localparam int DPP_W = (PAT_DEP > 1) ? $clog2(PAT_DEP) : 1;

    localparam logic [DPP_W-1:0] c_DPP_LAST = DPP_W'(PAT_DEP - 1);
    localparam logic [DPP_W-1:0] c_DPP_ONE  = DPP_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_DATA_ONE = WIDTH'(1);

    seq_state_e       state_q;
    logic             p_srdy_q;
    logic [WIDTH-1:0] p_data_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] remaining_q;
    logic [DPP_W-1:0] dpp_q;

    logic             xfer;
    logic             pat_bit;
    logic [DPP_W-1:0] dpp_d;
    logic [CNT_W-1:0] remaining_d;

    always_comb begin
        xfer        = p_srdy_q & p_drdy;
        pat_bit     = srdy_pat[dpp_q];
        dpp_d       = (dpp_q == c_DPP_LAST) ? '0 : dpp_q + c_DPP_ONE;
        remaining_d = remaining_q - c_CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEQ_IDLE;
            p_srdy_q    <= 1'b0;
            p_data_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            dpp_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (go) begin
                        state_q     <= SEQ_RUN;
                        busy_q      <= 1'b1;
                        remaining_q <= count;
                        dpp_q       <= '0;
                    end
                end

                SEQ_RUN: begin
                    if (xfer) begin
                        p_data_q    <= p_data_q + c_DATA_ONE;
                        remaining_q <= remaining_d;
                        dpp_q       <= dpp_d;
                        if (remaining_q == c_CNT_ONE) begin
                            state_q  <= SEQ_IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            p_srdy_q <= 1'b0;
                        end else begin
                            p_srdy_q <= pat_bit;
                        end
                    end else if (!p_srdy_q) begin
                        dpp_q <= dpp_d;
                        // A zero-length burst leaves after a single idle RUN cycle.
                        if (remaining_q == '0) begin
                            state_q <= SEQ_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            p_srdy_q <= pat_bit;
                        end
                    end
                end

                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign p_srdy = p_srdy_q;
    assign p_data = p_data_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : sd_seq_gen

`default_nettype wire

// File: tb/tb_sd_seq_gen.sv
// ============================================================================
// Module   : tb_sd_seq_gen
// Purpose  : Scoreboard bench for sd_seq_gen: expected words queued at burst
//            start, popped on every observed transfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_seq_gen;
    import sd_seq_pkg::*;

    localparam int WIDTH   = 8;
    localparam int PAT_DEP = 8;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               go;
    logic [CNT_W-1:0]   count;
    logic [PAT_DEP-1:0] srdy_pat;
    logic               p_srdy;
    logic               p_drdy;
    logic [WIDTH-1:0]   p_data;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_next = '0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    sd_seq_gen #(
        .WIDTH  (WIDTH),
        .PAT_DEP(PAT_DEP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .count   (count),
        .srdy_pat(srdy_pat),
        .p_srdy  (p_srdy),
        .p_drdy  (p_drdy),
        .p_data  (p_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 1'b1;
        end
    endtask

    // Ticks until done is seen; lat counts ticks including the one already taken.
    task automatic wait_done(input int start, input int budget, output int lat);
        lat = start;
        while (!done && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_burst(input int n, input int exp_lat, input string tag);
        int lat;
        push_words(n);
        go    = 1'b1;
        count = CNT_W'(n);
        tick();
        go = 1'b0;
        chk_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk_eq({tag, "_srdy_n1"}, {31'b0, p_srdy}, 32'd0);
        wait_done(1, exp_lat + 50, lat);
        chk_eq({tag, "_lat"}, lat, exp_lat);
        chk_eq({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        tick();
        chk_eq({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_next = '0;
        tick();
        reset = 1'b0;
    endtask

    // Transfer monitor: scoreboard pop plus protocol-hold check.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("hold_srdy", {31'b0, p_srdy}, 32'd1);
                chk_eq("hold_data", {24'b0, p_data}, {24'b0, prev_data});
            end
            if (p_srdy && p_drdy) begin
                if (exp_q.size() == 0)
                    chk_eq("extra_xfer", {24'b0, p_data}, 32'hFFFF_FFFF);
                else
                    chk_eq("data", {24'b0, p_data}, {24'b0, exp_q.pop_front()});
            end
            prev_stall = p_srdy && !p_drdy;
            prev_data  = p_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset    = 1'b1;
        go       = 1'b0;
        count    = '0;
        srdy_pat = PAT_FULL;
        p_drdy   = 1'b1;
        tick();
        tick();
        chk_eq("rst_srdy", {31'b0, p_srdy}, 32'd0);
        chk_eq("rst_data", {24'b0, p_data}, 32'd0);
        chk_eq("rst_busy", {31'b0, busy}, 32'd0);
        chk_eq("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        tick();

        // Full pattern: one word per cycle, done at go+6 for four words.
        do_burst(4, 6, "full4");
        do_burst(0, 2, "zero");
        chk_eq("zero_data", {24'b0, p_data}, 32'd4);
        do_burst(3, 5, "cont3");

        // Half pattern: srdy on every other RUN cycle.
        apply_reset();
        srdy_pat = PAT_HALF;
        push_words(4);
        go    = 1'b1;
        count = 16'd4;
        tick();
        go = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk_eq("half_srdy", {31'b0, p_srdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i < 8) tick();
        end
        tick();
        chk_eq("half_done", {31'b0, done}, 32'd1);
        tick();

        // Stall on the third word of the burst for three cycles.
        srdy_pat = PAT_FULL;
        push_words(4);
        go    = 1'b1;
        count = 16'd4;
        tick();
        go = 1'b0;
        tick();
        tick();
        tick();
        p_drdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_eq("stall_srdy", {31'b0, p_srdy}, 32'd1);
            chk_eq("stall_data", {24'b0, p_data}, 32'd6);
            tick();
        end
        p_drdy = 1'b1;
        wait_done(0, 50, lat);
        chk_eq("stall_resume_lat", lat, 2);
        tick();

        // go in the done cycle is accepted.
        push_words(2);
        go    = 1'b1;
        count = 16'd2;
        tick();
        go = 1'b0;
        wait_done(1, 50, lat);
        chk_eq("chain_first_lat", lat, 4);
        push_words(1);
        go    = 1'b1;
        count = 16'd1;
        tick();
        go = 1'b0;
        chk_eq("chain_busy", {31'b0, busy}, 32'd1);
        wait_done(1, 50, lat);
        chk_eq("chain_second_lat", lat, 3);
        tick();

        // Long burst wraps the 8-bit sequence.
        apply_reset();
        do_burst(300, 302, "wrap300");
        chk_eq("wrap_data", {24'b0, p_data}, 32'd44);

        // Reset while five words remain.
        apply_reset();
        push_words(10);
        go    = 1'b1;
        count = 16'd10;
        tick();
        go = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        exp_q.delete();
        exp_next = '0;
        tick();
        chk_eq("midrst_srdy", {31'b0, p_srdy}, 32'd0);
        chk_eq("midrst_data", {24'b0, p_data}, 32'd0);
        chk_eq("midrst_busy", {31'b0, busy}, 32'd0);
        chk_eq("midrst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        tick();
        chk_eq("midrst_done2", {31'b0, done}, 32'd0);
        do_burst(2, 4, "after_rst");

        chk_eq("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sd_seq_gen

`default_nettype wire
